divfreq_bank: RTL and testbench



---
 rtl/divfreq_pkg.sv | 26 ++
 rtl/divfreq_stage.sv | 65 ++++++
 rtl/divfreq_bank.sv | 59 +++++
 tb/tb_divfreq_bank.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/divfreq_pkg.sv
// Shared defaults and elaboration-time helpers for the clock-divider bank.
package divfreq_pkg;

  localparam int unsigned DefClkHz = 50_000_000;
  localparam int unsigned DefFFast = 1000;
  localparam int unsigned DefFStep = 6;
  localparam int unsigned DefFSlow = 1;

  // Half-period in clk cycles, truncating; 0 flags an unusable request.
  function automatic int unsigned half_period(input int unsigned clk_hz,
                                              input int unsigned f_hz);
    if (f_hz == 0) begin
      return 0;
    end
    return clk_hz / (2 * f_hz);
  endfunction

  // Counter width able to hold 0..half-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned half);
    if (half <= 1) begin
      return 1;
    end
    return $clog2(half);
  endfunction

endpackage

// File: rtl/divfreq_stage.sv
// One free-running divider: square wave at F_HZ, 50 % duty, driven from a flop.
// Optional DIVFREQ_TICK_EN adds a one-cycle pulse coincident with each rise.
module divfreq_stage
  import divfreq_pkg::*;
#(
  parameter int unsigned CLK_HZ = DefClkHz,
  parameter int unsigned F_HZ   = DefFSlow
) (
  input  logic clk,
  input  logic rst,
`ifdef DIVFREQ_TICK_EN
  output logic tick,
`endif
  output logic out
);

  localparam int unsigned Half = half_period(CLK_HZ, F_HZ);
  localparam int unsigned CntW = cnt_width(Half);

  if (Half < 1) begin : g_bad_half
    $fatal(1, "divfreq_stage: half period below one clk cycle");
  end

  localparam logic [CntW-1:0] CntMax = CntW'(Half - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            out_q, out_d;
  logic            wrap;

  // Next state: wrap the counter and toggle the output at the end of a half-period.
  always_comb begin
    wrap  = (cnt_q == CntMax);
    cnt_d = wrap ? '0 : cnt_q + 1'b1;
    out_d = wrap ? ~out_q : out_q;
  end

  // Counter and output flops; reset aborts the current half-period.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      out_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      out_q <= out_d;
    end
  end

  assign out = out_q;

`ifdef DIVFREQ_TICK_EN
  logic tick_q;

  // Pulse on the same edge the output rises (wrap while currently low).
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_q <= 1'b0;
    end else begin
      tick_q <= wrap & ~out_q;
    end
  end

  assign tick = tick_q;
`endif

endmodule

// File: rtl/divfreq_bank.sv
// Three independent free-running dividers (row scan, game step, game timer)
// sharing one synchronous reset. DIVFREQ_TICK_EN adds per-output rise ticks.
module divfreq_bank
  import divfreq_pkg::*;
#(
  parameter int unsigned CLK_HZ = DefClkHz,
  parameter int unsigned F_FAST = DefFFast,
  parameter int unsigned F_STEP = DefFStep,
  parameter int unsigned F_SLOW = DefFSlow
) (
  input  logic clk,
  input  logic rst,
`ifdef DIVFREQ_TICK_EN
  output logic tick_1000,
  output logic tick_6,
  output logic tick_1,
`endif
  output logic clk_1000,
  output logic clk_6,
  output logic clk_1
);

  divfreq_stage #(
    .CLK_HZ (CLK_HZ),
    .F_HZ   (F_FAST)
  ) u_fast (
    .clk  (clk),
    .rst  (rst),
`ifdef DIVFREQ_TICK_EN
    .tick (tick_1000),
`endif
    .out  (clk_1000)
  );

  divfreq_stage #(
    .CLK_HZ (CLK_HZ),
    .F_HZ   (F_STEP)
  ) u_step (
    .clk  (clk),
    .rst  (rst),
`ifdef DIVFREQ_TICK_EN
    .tick (tick_6),
`endif
    .out  (clk_6)
  );

  divfreq_stage #(
    .CLK_HZ (CLK_HZ),
    .F_HZ   (F_SLOW)
  ) u_slow (
    .clk  (clk),
    .rst  (rst),
`ifdef DIVFREQ_TICK_EN
    .tick (tick_1),
`endif
    .out  (clk_1)
  );

endmodule

// File: tb/tb_divfreq_bank.sv
// Directed bench for divfreq_bank at CLK_HZ = 12_000 (half periods 6 / 1000 / 6000).
module tb_divfreq_bank;
  import divfreq_pkg::*;

  localparam int unsigned ClkHz = 12_000;
  localparam int unsigned HFast = 6;
  localparam int unsigned HStep = 1000;
  localparam int unsigned HSlow = 6000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clk_1000, clk_6, clk_1;
`ifdef DIVFREQ_TICK_EN
  logic tick_1000, tick_6, tick_1;
`endif

  divfreq_bank #(
    .CLK_HZ (ClkHz),
    .F_FAST (1000),
    .F_STEP (6),
    .F_SLOW (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef DIVFREQ_TICK_EN
    .tick_1000 (tick_1000),
    .tick_6    (tick_6),
    .tick_1    (tick_1),
`endif
    .clk_1000  (clk_1000),
    .clk_6     (clk_6),
    .clk_1     (clk_1)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int unsigned n;  // edges since reset release
  int err_fast, err_step, err_slow, err_tick;
  int rise_fast, rise_step, rise_slow, tick_cnt;
  logic prev_fast, prev_step, prev_slow;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic model(input int unsigned edges, input int unsigned half);
    return ((edges / half) % 2) == 1;
  endfunction

  function automatic logic model_tick(input int unsigned edges, input int unsigned half);
    return (edges % (2 * half)) == half;
  endfunction

  task automatic clear_stats();
    err_fast = 0; err_step = 0; err_slow = 0; err_tick = 0;
    rise_fast = 0; rise_step = 0; rise_slow = 0; tick_cnt = 0;
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    prev_fast = 1'b0; prev_step = 1'b0; prev_slow = 1'b0;
  endtask

  // Advance with rst low, comparing every edge against the ideal waveform.
  task automatic run_free(input int unsigned count);
    for (int unsigned i = 0; i < count; i++) begin
      @(posedge clk);
      #1;
      n++;
      if (clk_1000 !== model(n, HFast)) err_fast++;
      if (clk_6    !== model(n, HStep)) err_step++;
      if (clk_1    !== model(n, HSlow)) err_slow++;
      if (clk_1000 && !prev_fast) rise_fast++;
      if (clk_6    && !prev_step) rise_step++;
      if (clk_1    && !prev_slow) rise_slow++;
      prev_fast = clk_1000; prev_step = clk_6; prev_slow = clk_1;
`ifdef DIVFREQ_TICK_EN
      if (tick_1000 !== model_tick(n, HFast)) err_tick++;
      if (tick_6    !== model_tick(n, HStep)) err_tick++;
      if (tick_1    !== model_tick(n, HSlow)) err_tick++;
      if (tick_1000) tick_cnt++;
`endif
    end
  endtask

  initial begin
    int hold_bad;

    // Truncating half-period at the board clock.
    check_eq("half_step_50m", half_period(50_000_000, 6), 32'd4_166_666);
    check_eq("half_fast_50m", half_period(50_000_000, 1000), 32'd25_000);

    // Reset state.
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_outs", {29'd0, clk_1000, clk_6, clk_1}, 32'd0);
`ifdef DIVFREQ_TICK_EN
    check_eq("reset_ticks", {29'd0, tick_1000, tick_6, tick_1}, 32'd0);
`endif

    // Release and first edges.
    clear_stats();
    release_rst();
    run_free(5);
    check_eq("fast_e5", {31'd0, clk_1000}, 32'd0);
    run_free(1);
    check_eq("fast_e6", {31'd0, clk_1000}, 32'd1);
    run_free(5);
    check_eq("fast_e11", {31'd0, clk_1000}, 32'd1);
    run_free(1);
    check_eq("fast_e12", {31'd0, clk_1000}, 32'd0);
    run_free(987);
    check_eq("step_e999", {31'd0, clk_6}, 32'd0);
    run_free(1);
    check_eq("step_e1000", {31'd0, clk_6}, 32'd1);
    run_free(4999);
    check_eq("slow_e5999", {31'd0, clk_1}, 32'd0);
    run_free(1);
    check_eq("slow_e6000", {31'd0, clk_1}, 32'd1);

    // Free run to 24_000 edges.
    run_free(24_000 - 6000);
    check_eq("free_n", n, 32'd24_000);
    check_eq("free_err_fast", err_fast, 32'd0);
    check_eq("free_err_step", err_step, 32'd0);
    check_eq("free_err_slow", err_slow, 32'd0);
    check_eq("free_rise_fast", rise_fast, 32'd2000);
    check_eq("free_rise_step", rise_step, 32'd12);
    check_eq("free_rise_slow", rise_slow, 32'd2);
`ifdef DIVFREQ_TICK_EN
    check_eq("free_err_tick", err_tick, 32'd0);
    check_eq("free_tick_cnt", tick_cnt, rise_fast);
`endif

    // Mid-period reset with clk_6 high and its counter at 500.
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    clear_stats();
    release_rst();
    run_free(1500);
    check_eq("mid_step_high", {31'd0, clk_6}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_eq("mid_reset_outs", {29'd0, clk_1000, clk_6, clk_1}, 32'd0);
    clear_stats();
    release_rst();
    run_free(999);
    check_eq("mid_step_e999", {31'd0, clk_6}, 32'd0);
    run_free(1);
    check_eq("mid_step_e1000", {31'd0, clk_6}, 32'd1);
    check_eq("mid_err_fast", err_fast, 32'd0);
    check_eq("mid_err_step", err_step, 32'd0);

    // Reset held for 50 cycles starting from clk_1000 high.
    run_free(4);
    check_eq("hold_pre_fast", {31'd0, clk_1000}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    hold_bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      if ({clk_1000, clk_6, clk_1} != 3'b000) hold_bad++;
`ifdef DIVFREQ_TICK_EN
      if ({tick_1000, tick_6, tick_1} != 3'b000) hold_bad++;
`endif
    end
    check_eq("hold_nonzero", hold_bad, 32'd0);
    clear_stats();
    release_rst();
    run_free(12);
    check_eq("hold_recover_err", err_fast, 32'd0);
    check_eq("hold_recover_rise", rise_fast, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
